// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit common-anode 7-segment scan driver:
// active-low idle values, the hex glyph table and the digit-index width.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam int         IDX_W   = 2;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for value n (hex A-F as A b C d E F).
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_scan_display_decode.sv
// Combinational hex decoder: 4-bit value to active-low 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] pattern
);

  assign pattern = GLYPHS[value];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit 7-segment driver with per-slot blanking guard and
// per-frame input snapshot. Define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 10_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int GUARD_CYCLES = 100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] sign0,
  input  logic [3:0] sign1,
  input  logic [3:0] sign2,
  input  logic [3:0] sign3,
  output logic [6:0] segments,
  output logic [3:0] displays,
  output logic       frame_o
);

  localparam int DWELL = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);

  generate
    if (DWELL < GUARD_CYCLES + 2) begin : g_bad_dwell
      $error("seg7_scan_display: DWELL must be at least GUARD_CYCLES + 2");
    end
  endgenerate

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [3:0][3:0]       snap;
  logic                  snapshot;
  logic [3:0]            cur_value;
  logic [6:0]            cur_glyph;
  logic                  lead_blank;
  logic [3:0]            slot_an;
  logic [6:0]            slot_seg;
  logic [3:0]            stage_an;
  logic [6:0]            stage_seg;

  assign snapshot = (cnt == '0) && (idx == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap    <= '0;
      frame_o <= 1'b0;
    end else begin
      frame_o <= snapshot;
      if (snapshot) snap <= {sign3, sign2, sign1, sign0};
    end
  end

  assign cur_value = snap[idx];

  seg7_decode u_decode (
    .value   (cur_value),
    .pattern (cur_glyph)
  );

  always_comb begin
    lead_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3:    lead_blank = (snap[3] == 4'd0);
      2'd2:    lead_blank = (snap[3] == 4'd0) && (snap[2] == 4'd0);
      2'd1:    lead_blank = (snap[3] == 4'd0) && (snap[2] == 4'd0) && (snap[1] == 4'd0);
      default: lead_blank = 1'b0;
    endcase
`endif
  end

  always_comb begin
    slot_an  = AN_OFF;
    slot_seg = SEG_OFF;
    if (cnt >= CNT_GUARD) begin
      slot_an  = ~(4'b0001 << idx);
      slot_seg = lead_blank ? SEG_OFF : cur_glyph;
    end
  end

  // Two register stages: the first freezes the glyph against the snapshot it
  // was computed from, so a snapshot on a slot boundary never mixes frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_an  <= AN_OFF;
      stage_seg <= SEG_OFF;
      displays  <= AN_OFF;
      segments  <= SEG_OFF;
    end else begin
      stage_an  <= slot_an;
      stage_seg <= slot_seg;
      displays  <= stage_an;
      segments  <= stage_seg;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized self-checking bench for seg7_scan_display against a frame/slot
// arithmetic reference model (DWELL=10, GUARD_CYCLES=2).
module tb_seg7_scan_display;

  localparam int DWELL = 10;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DWELL;
  localparam logic [10:0] BLANK = {4'b1111, 7'b1111111};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sign0, sign1, sign2, sign3;
  logic [6:0] segments;
  logic [3:0] displays;
  logic       frame_o;

  int checks = 0;
  int failures = 0;

  // Reference state: cycles since reset release, the frame's captured digits,
  // and expected outputs ({displays, segments}) queued by output latency.
  int          j;
  logic [3:0]  snap_m [4];
  logic [10:0] exp_q [$];
  logic [10:0] exp_out;
  logic        exp_frame;

  seg7_scan_display #(
    .CLK_HZ       (1000),
    .DIGIT_HZ     (100),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .sign0    (sign0),
    .sign1    (sign1),
    .sign2    (sign2),
    .sign3    (sign3),
    .segments (segments),
    .displays (displays),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // What the display should show for scan cycle jj of the current frame.
  function automatic logic [10:0] model_out(input int jj);
    int         pos;
    int         d;
    logic [3:0] an;
    logic [6:0] seg;
    bit         hide;
    pos = jj % DWELL;
    d   = (jj / DWELL) % 4;
    if (pos < GUARD) return BLANK;
    an   = 4'b1111;
    an[d] = 1'b0;
    hide = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      hide = 1'b1;
      for (int k = d; k < 4; k++) if (snap_m[k] != 4'd0) hide = 1'b0;
    end
`endif
    seg = hide ? 7'b1111111 : glyph(snap_m[d]);
    return {an, seg};
  endfunction

  // One clock: update the model from the inputs present before the edge,
  // then compare all outputs shortly after the edge.
  task automatic tick();
    if (rst) begin
      j = 0;
      for (int k = 0; k < 4; k++) snap_m[k] = 4'd0;
      exp_q.delete();
      exp_q.push_back(BLANK);
      exp_out   = BLANK;
      exp_frame = 1'b0;
    end else begin
      if (j % FRAME == 0) begin
        snap_m[0] = sign0; snap_m[1] = sign1; snap_m[2] = sign2; snap_m[3] = sign3;
      end
      exp_out   = exp_q.pop_front();
      exp_q.push_back(model_out(j));
      exp_frame = (j % FRAME == 0);
      j++;
    end
    @(posedge clk);
    #1;
    check("displays", 32'(displays), 32'(exp_out[10:7]));
    check("segments", 32'(segments), 32'(exp_out[6:0]));
    check("frame_o", 32'(frame_o), 32'(exp_frame));
    check("one_anode", 32'($countones(~displays) <= 1), 32'd1);
  endtask

  task automatic run_to(input int phase);
    for (int k = 0; k < FRAME && (j % FRAME) != phase; k++) tick();
    check("run_to_phase", 32'(j % FRAME), 32'(phase));
  endtask

  // Reset edge(s) then release, with the fixed start-up checks for inputs 1,2,3,4.
  task automatic reset_release(input int cycles);
    sign3 = 4'd1; sign2 = 4'd2; sign1 = 4'd3; sign0 = 4'd4;
    rst = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      tick();
      check("reset_displays", 32'(displays), 32'hF);
      check("reset_segments", 32'(segments), 32'h7F);
      check("reset_frame", 32'(frame_o), 32'd0);
    end
    rst = 1'b0;
    for (int t = 0; t < 24; t++) begin
      tick();
      if (t == 0) check("e1_frame", 32'(frame_o), 32'd1);
      if (t == 1) check("e1p1_frame", 32'(frame_o), 32'd0);
      if (t == 2) check("pre_anode", 32'(displays), 32'hF);
      if (t == 3) begin
        check("first_anode", 32'(displays), 32'hE);
        check("first_glyph", 32'(segments), 32'h19);
      end
      if (t == 10) check("digit0_last", 32'(displays), 32'hE);
      if (t == 11 || t == 12) check("guard_blank", 32'(displays), 32'hF);
      if (t == 13) begin
        check("digit1_anode", 32'(displays), 32'hD);
        check("digit1_glyph", 32'(segments), 32'h30);
      end
    end
  endtask

  initial begin
    int frames;
    rst = 1'b1;
    sign0 = '0; sign1 = '0; sign2 = '0; sign3 = '0;

    reset_release(2);

    // Steady scan over three frames with random digits.
    sign0 = 4'($urandom_range(0, 15)); sign1 = 4'($urandom_range(0, 15));
    sign2 = 4'($urandom_range(0, 15)); sign3 = 4'($urandom_range(0, 15));
    frames = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      tick();
      if (frame_o) frames++;
    end
    check("frames_in_120", 32'(frames), 32'd3);

    // Glitch on sign0 between snapshots must stay invisible.
    run_to(0);
    sign0 = 4'd4;
    tick();
    run_to(25);
    sign0 = 4'd9;
    run_to(35);
    sign0 = 4'd4;
    for (int k = 0; k < FRAME + 5; k++) tick();

    // Hex sweep: sign0 takes each value for one frame.
    for (int v = 0; v < 16; v++) begin
      run_to(0);
      sign0 = 4'(v);
      sign1 = 4'($urandom_range(0, 15)); sign2 = 4'($urandom_range(0, 15));
      sign3 = 4'($urandom_range(0, 15));
      for (int k = 0; k < FRAME; k++) begin
        tick();
        if (k == 3) check("hex_glyph", 32'(segments), 32'(glyph(4'(v))));
      end
    end

    // Leading zeros (blanked only in the LEADING_ZERO_BLANK_EN build).
    run_to(0);
    sign3 = 4'd0; sign2 = 4'd0; sign1 = 4'd5; sign0 = 4'd7;
    for (int k = 0; k < 2 * FRAME + 2; k++) tick();

    // Single-cycle reset in the middle of the digit-2 drive.
    run_to(25);
    reset_release(1);
    for (int k = 0; k < FRAME; k++) tick();

    // Random inputs changing at random times.
    for (int k = 0; k < 4 * FRAME; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        sign0 = 4'($urandom_range(0, 15)); sign1 = 4'($urandom_range(0, 15));
        sign2 = 4'($urandom_range(0, 15)); sign3 = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
